// File: rtl/phase_pkg.sv
// phase_pkg: shared phase width, derotator state encoding and a width-generic rotl golden function
package phase_pkg;
    localparam int K_W = 2;
    localparam int MAX_W = 1024;

    typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

    // rotl over the low w bits of x (w <= MAX_W); bits at and above w return 0
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int w, input logic [K_W-1:0] k);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[(i + int'(k)) % w] = x[i];
        return r;
    endfunction
endpackage

// File: rtl/phase_rotl.sv
// phase_rotl: combinational left rotate of a W-bit word by a 2-bit amount
//   x : word in, k : rotate amount (0 = identity), y : rotated word
module phase_rotl
    import phase_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0]   x,
    input  logic [K_W-1:0] k,
    output logic [W-1:0]   y
);
    assign y = k == 2'd0 ? x
             : k == 2'd1 ? {x[W-2:0], x[W-1]}
             : k == 2'd2 ? {x[W-3:0], x[W-1:W-2]}
             :             {x[W-4:0], x[W-1:W-3]};
endmodule

// File: rtl/phase_2b_derot.sv
// phase_2b_derot: collects a serial phase-rotated frame, rotates it back left by its phase, presents it in parallel
//   clk, rst (async, active high)
//   in_valid/in_ready/in_bit/in_k  : serial beat handshake, in_k sampled on the first beat only
//   out_valid/out_ready/out_bits/out_k : realigned frame handshake and the removed phase
//   out_ones : popcount of out_bits, only when PHASE_2B_DEROT_POPCNT_EN is defined
module phase_2b_derot
    import phase_pkg::*;
#(
    parameter int BITSTREAM = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_bit,
    input  logic [K_W-1:0]       in_k,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITSTREAM-1:0] out_bits,
    output logic [K_W-1:0]       out_k
`ifdef PHASE_2B_DEROT_POPCNT_EN
    ,
    output logic [$clog2(BITSTREAM+1)-1:0] out_ones
`endif
);
    localparam int CW = $clog2(BITSTREAM);

    state_t               state, state_n;
    logic [CW-1:0]        cnt;
    logic [BITSTREAM-1:0] sr, sr_n, rot;
    logic [K_W-1:0]       k_q;
    logic                 beat, last;

    // the final beat is rotated together with the register contents, so no extra cycle is spent
    assign sr_n = {in_bit, sr[BITSTREAM-1:1]};

    phase_rotl #(.W(BITSTREAM)) u_rotl (.x(sr_n), .k(k_q), .y(rot));

`ifdef PHASE_2B_DEROT_POPCNT_EN
    localparam int OW = $clog2(BITSTREAM+1);
    logic [OW-1:0] ones_n;
    always_comb begin
        ones_n = '0;
        for (int i = 0; i < BITSTREAM; i++)
            ones_n = ones_n + OW'(rot[i]);
    end
`endif

    always_comb begin
        in_ready  = state != OUTPUT;
        out_valid = state == OUTPUT;
        beat      = in_valid && in_ready;
        last      = state == COLLECT && cnt == CW'(BITSTREAM-1);
        state_n   = state;
        if (state == IDLE && beat)
            state_n = COLLECT;
        else if (last && beat)
            state_n = OUTPUT;
        else if (state == OUTPUT && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            k_q      <= '0;
            out_bits <= '0;
            out_k    <= '0;
`ifdef PHASE_2B_DEROT_POPCNT_EN
            out_ones <= '0;
`endif
        end else begin
            state <= state_n;
            if (beat) begin
                sr <= sr_n;
                if (state == IDLE) begin
                    k_q <= in_k;
                    cnt <= CW'(1);
                end else if (last) begin
                    cnt      <= '0;
                    out_bits <= rot;
                    out_k    <= k_q;
`ifdef PHASE_2B_DEROT_POPCNT_EN
                    out_ones <= ones_n;
`endif
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_phase_2b_derot.sv
// tb_phase_2b_derot: directed table vectors plus hand-written sequences for the derotator
module tb_phase_2b_derot;
    import phase_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_bit;
    logic [1:0]   in_k;
    logic         out_valid, out_ready;
    logic [W-1:0] out_bits;
    logic [1:0]   out_k;
`ifdef PHASE_2B_DEROT_POPCNT_EN
    logic [6:0]   out_ones;
`endif

    int checks = 0;
    int failures = 0;

    phase_2b_derot #(.BITSTREAM(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_k(in_k),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_k(out_k)
`ifdef PHASE_2B_DEROT_POPCNT_EN
        , .out_ones(out_ones)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic [1:0]   k;
        logic [W-1:0] exp;
        int           ones;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // advance to the next falling edge; in_ready must always be the inverse of out_valid
    task automatic tick();
        @(negedge clk);
        if (!rst) chk("ready_vs_valid", 64'(in_ready), 64'(!out_valid));
    endtask

    function automatic logic [W-1:0] rotr(input logic [W-1:0] f, input logic [1:0] k);
        return k == 2'd0 ? f : (f >> k) | (f << (W - int'(k)));
    endfunction

    function automatic logic [W-1:0] golden(input logic [W-1:0] s, input logic [1:0] k);
        logic [MAX_W-1:0] t;
        t = '0;
        t[W-1:0] = s;
        t = rotl(t, W, k);
        return t[W-1:0];
    endfunction

    task automatic send_beat(input logic b, input logic [1:0] k);
        int budget;
        in_valid = 1'b1;
        in_bit   = b;
        in_k     = k;
        budget   = 0;
        while (!in_ready && budget < 100) begin
            tick();
            budget++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
        end
        tick();
        in_valid = 1'b0;
    endtask

    // beats 0..n-1 of a serial word, k0 on beat 0 and kr afterwards, optional random idle gaps
    task automatic send_bits(input logic [W-1:0] s, input int n, input logic [1:0] k0, input logic [1:0] kr, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_k = 2'(~kr);
                repeat ($urandom_range(1, 3)) tick();
            end
            send_beat(s[i], i == 0 ? k0 : kr);
        end
    endtask

    task automatic take(input string name, input logic [W-1:0] exp, input logic [1:0] ek, input int ones);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_bits"}, out_bits, exp);
        chk({name, "_k"}, 64'(out_k), 64'(ek));
`ifdef PHASE_2B_DEROT_POPCNT_EN
        if (ones >= 0) chk({name, "_ones"}, 64'(out_ones), 64'(ones));
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({name, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] f, held;
        logic [1:0]   k;

        vecs[0] = '{64'h8000_0000_0000_0000, 2'd1, 64'h0000_0000_0000_0001, 1};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 2'd0, 64'h0123_4567_89AB_CDEF, 32};
        vecs[2] = '{64'hE024_68AC_F135_79BD, 2'd3, 64'h0123_4567_89AB_CDEF, 32};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[4] = '{64'h0000_0000_0000_0000, 2'd3, 64'h0000_0000_0000_0000, 0};
        vecs[5] = '{64'h0000_0000_0000_0001, 2'd2, 64'h0000_0000_0000_0004, 1};
        vecs[6] = '{64'h8000_0000_0000_0000, 2'd3, 64'h0000_0000_0000_0004, 1};
        vecs[7] = '{64'h0000_0000_0000_0001, 2'd0, 64'h0000_0000_0000_0001, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_bit = 1'b0;
        in_k = 2'd0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_bits", out_bits, 64'd0);
        chk("reset_k", 64'(out_k), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("early_ready_no_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        foreach (vecs[i]) begin
            send_bits(vecs[i].s, W - 1, vecs[i].k, vecs[i].k, 1'b0);
            chk($sformatf("vec%0d_not_early", i), 64'(out_valid), 64'd0);
            send_beat(vecs[i].s[W-1], vecs[i].k);
            take($sformatf("vec%0d", i), vecs[i].exp, vecs[i].k, vecs[i].ones);
        end

        send_bits(64'h0123_4567_89AB_CDEF, W, 2'd2, 2'd1, 1'b0);
        take("k_change", golden(64'h0123_4567_89AB_CDEF, 2'd2), 2'd2, -1);

        f = 64'hDEAD_BEEF_0BAD_F00D;
        send_bits(rotr(f, 2'd1), W, 2'd1, 2'd1, 1'b0);
        held = out_bits;
        in_valid = 1'b1;
        in_bit = 1'b1;
        repeat (20) begin
            tick();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready_low", 64'(in_ready), 64'd0);
            chk("bp_hold", out_bits, held);
        end
        in_valid = 1'b0;
        take("bp", f, 2'd1, -1);
        f = 64'h5A5A_0F0F_3C3C_9669;
        send_bits(rotr(f, 2'd2), W, 2'd2, 2'd2, 1'b0);
        take("after_bp", f, 2'd2, -1);

        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 30, 2'd3, 2'd3, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_bits", out_bits, 64'd0);
        chk("async_rst_k", 64'(out_k), 64'd0);
`ifdef PHASE_2B_DEROT_POPCNT_EN
        chk("async_rst_ones", 64'(out_ones), 64'd0);
`endif
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("abort_no_output", 64'(out_valid), 64'd0);
        end
        f = 64'h1357_9BDF_2468_ACE0;
        send_bits(rotr(f, 2'd3), W, 2'd3, 2'd3, 1'b0);
        take("after_rst", f, 2'd3, -1);

        for (int n = 0; n < 100; n++) begin
            f = {32'($urandom), 32'($urandom)};
            k = 2'($urandom_range(0, 3));
            send_bits(rotr(f, k), W, k, k, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
            take("rand", f, k, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phase_2b_derot.md
# phase_2b_derot

Receive-side counterpart of the 2-bit phase rotator. Collects a serially delivered, phase-rotated stochastic bitstream frame of BITSTREAM bits. Undoes the rotation by rotating left by the frame's phase k, and presents the realigned frame in parallel behind a valid/ready handshake. It sits between the serial bitstream link and the downstream SC arithmetic that expects phase-0 frames.

## Interface
- BITSTREAM, 64, frame length in bits; legal range ≥ 4.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  serial beat valid.
- in_ready  output  1  block can accept a beat.
- in_bit  input  1  serial data bit; the first beat of a frame is bit 0.
- in_k  input  2  phase of the frame; sampled only on the first beat.
- out_valid  output  1  realigned frame available.
- out_ready  input  1  downstream accepts the frame.
- out_bits  output  BITSTREAM  realigned frame.
- out_k  output  2  phase that was removed from the frame.
- out_ones  output  $clog2(BITSTREAM+1)  popcount of out_bits; present only with PHASE_2B_DEROT_POPCNT_EN.

## Operation
- The state machine has three states: IDLE, COLLECT, OUTPUT.
- A beat is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and COLLECT, and 0 in OUTPUT.
- IDLE: an accepted beat does three things.
  - It latches in_k into k_q.
  - It shifts in_bit into the shift register as sr <= {in_bit, sr[W-1:1]}.
  - It sets cnt = 1 and moves to COLLECT.
- COLLECT: each accepted beat shifts in and increments cnt. Cycles without a beat hold all state, so any number of idle gaps are allowed.
- Final beat of a frame (cnt == W-1 with an accepted beat):
  - Register out_bits = rotl({in_bit, sr[W-1:1]}, k_q), where rotl(x,k) = (x << k) | (x >> (W-k)), and k = 0 is identity.
  - Register out_k = k_q.
  - Move to OUTPUT.
- OUTPUT: out_valid = 1. out_bits, out_k and out_ones are held stable until out_valid && out_ready, then the block returns to IDLE.
- in_k changes after the first beat are ignored for the rest of that frame.
- Invariant: for any frame F and phase k, serially sending rotr(F,k) with in_k = k yields out_bits == F.

## Timing
- Reset values: state = IDLE, cnt = 0, sr = 0, out_bits = 0, out_k = 0, out_ones = 0, out_valid = 0, in_ready = 1.
- Latency: out_valid rises on the cycle after the final beat is accepted.
- Throughput: at best W beats plus 1 handshake cycle per frame. in_ready returns to 1 on the cycle after the output handshake.
- out_ready asserted before out_valid has no effect.
- in_valid asserted while in OUTPUT is not accepted. The upstream must hold its beat.
- Reset asserted mid-frame or mid-OUTPUT discards the partial or pending frame immediately, asynchronously. Nothing is emitted for it.
- Wrap-around: cnt never exceeds W-1. It clears when the block enters OUTPUT.

## Configuration
- PHASE_2B_DEROT_POPCNT_EN defined:
  - The out_ones port exists.
  - The popcount is computed from the rotated frame and registered in the same cycle as out_bits, so it adds no extra latency.
- PHASE_2B_DEROT_POPCNT_EN not defined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package phase_pkg holds:
  - localparam K_W = 2;
  - the state enum typedef (IDLE, COLLECT, OUTPUT);
  - a rotl function parameterized on width, which the verification side also uses as its golden model.
- One sub-module: phase_rotl, a purely combinational left rotator (width parameter, 2-bit k). It is instantiated once on the shift-register-plus-final-bit path.

## Test plan
- W = 64, k = 1, serial frame 0x8000_0000_0000_0000 (bit 0 first) -> out_bits = 0x0000_0000_0000_0001, out_k = 1, out_valid on the cycle after beat 64, out_ones = 1.
- k = 0, frame 0x0123_4567_89AB_CDEF -> out_bits = 0x0123_4567_89AB_CDEF. Also k = 3 on rotr(0x0123_4567_89AB_CDEF, 3) -> out_bits = 0x0123_4567_89AB_CDEF.
- Random gaps: in_valid toggled pseudo-randomly over 100 frames with random F and k = 0..3 -> every out_bits == F and out_k == k. in_ready is 0 exactly while out_valid is 1.
- Backpressure: out_ready held 0 for 20 cycles after out_valid -> out_bits held stable and no beats accepted. On out_ready = 1, out_valid drops next cycle and in_ready = 1.
- Mid-frame in_k change: in_k = 2 on beat 0, then 1 from beat 1 onward -> rotation uses k = 2 and out_k = 2.
- Reset at beat 30 of a frame, then a full new frame -> no output for the aborted frame. The new frame is realigned correctly, and all outputs read their reset values while rst = 1.
